// File: rtl/fence_pkg.sv
// fence_pkg: FSM states, width helpers and N_PTS legality limits for fence_ccw_sort
package fence_pkg;
  typedef enum logic [2:0] {RECV, VEC, RANK, PLACE, OUT} state_t;
  localparam int N_MIN = 3;
  localparam int N_MAX = 16;
  function automatic bit n_legal(input int n);
    return n >= N_MIN && n <= N_MAX;
  endfunction
  function automatic int vec_w(input int cw);
    return cw + 1;
  endfunction
  function automatic int cross_w(input int cw);
    return 2 * cw + 3;
  endfunction
  function automatic int area_w(input int cw, input int n);
    return 2 * cw + $clog2(n) + 2;
  endfunction
endpackage

// File: rtl/fence_cross.sv
// fence_cross: signed cross product a.x*b.y - b.x*a.y with sign/zero flags; full value exported under FENCE_AREA_EN
module fence_cross import fence_pkg::*; #(
  parameter int CW = 8
) (
  input logic signed [CW:0] ax,
  input logic signed [CW:0] ay,
  input logic signed [CW:0] bx,
  input logic signed [CW:0] by,
`ifdef FENCE_AREA_EN
  output logic signed [cross_w(CW)-1:0] c,
`endif
  output logic neg,
  output logic zero
);
  localparam int XW = cross_w(CW);
  logic signed [XW-1:0] cv;
  // operands are widened before multiplying so neither product nor difference can overflow
  always_comb begin
    cv = XW'(ax) * XW'(by) - XW'(bx) * XW'(ay);
    neg = cv[XW-1];
    zero = cv == '0;
  end
`ifdef FENCE_AREA_EN
  assign c = cv;
`endif
endmodule

// File: rtl/fence_ccw_sort.sv
// fence_ccw_sort: collects N_PTS points, ranks them by angle about point 0, streams them counter-clockwise; FENCE_AREA_EN adds area2
module fence_ccw_sort import fence_pkg::*; #(
  parameter int N_PTS = 6,
  parameter int CW = 8,
  parameter int REL_OUT = 0
) (
  input logic clk,
  input logic reset,
  input logic give_valid,
  input logic [CW-1:0] dataX,
  input logic [CW-1:0] dataY,
  output logic in_ready,
  output logic signed [CW:0] ansX,
  output logic signed [CW:0] ansY,
  output logic out_valid,
  output logic out_last
`ifdef FENCE_AREA_EN
  ,
  output logic signed [area_w(CW, N_PTS)-1:0] area2
`endif
);
  localparam int IW = $clog2(N_PTS);
  localparam int VW = vec_w(CW);
  localparam logic [IW-1:0] LAST = IW'(N_PTS - 1);
  state_t state, nxt;
  logic [IW-1:0] idx, k, j, nidx;
  logic [CW-1:0] px [N_PTS];
  logic [CW-1:0] py [N_PTS];
  logic signed [VW-1:0] vx [N_PTS];
  logic signed [VW-1:0] vy [N_PTS];
  logic signed [VW-1:0] bx [N_PTS];
  logic signed [VW-1:0] by [N_PTS];
  logic [IW-1:0] rank [N_PTS];
  logic signed [VW-1:0] cax, cay, cbx, cby;
  logic cneg, czero;
`ifdef FENCE_AREA_EN
  localparam int AW = area_w(CW, N_PTS);
  logic signed [cross_w(CW)-1:0] c;
`endif
  assign in_ready = state == RECV;
  assign nidx = idx == LAST ? '0 : idx + 1'b1;
  // one cross unit: the (k,j) vector pair while ranking, consecutive output slots while streaming
  always_comb begin
`ifdef FENCE_AREA_EN
    cax = state == OUT ? bx[idx] : vx[k];
    cay = state == OUT ? by[idx] : vy[k];
    cbx = state == OUT ? bx[nidx] : vx[j];
    cby = state == OUT ? by[nidx] : vy[j];
`else
    cax = vx[k];
    cay = vy[k];
    cbx = vx[j];
    cby = vy[j];
`endif
  end
  fence_cross #(.CW(CW)) u_cross (
    .ax(cax),
    .ay(cay),
    .bx(cbx),
    .by(cby),
`ifdef FENCE_AREA_EN
    .c(c),
`endif
    .neg(cneg),
    .zero(czero)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= RECV;
    else state <= nxt;
  // next-state: each phase ends on the last point, pair or slot
  always_comb begin
    nxt = state;
    case (state)
      RECV: nxt = give_valid && idx == LAST ? VEC : RECV;
      VEC: nxt = RANK;
      RANK: nxt = k == LAST && j == LAST ? PLACE : RANK;
      PLACE: nxt = OUT;
      OUT: nxt = idx == LAST ? RECV : OUT;
      default: nxt = RECV;
    endcase
  end
  // datapath: capture, vectorise, rank by pairwise cross sign, permute, stream
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx <= '0;
      k <= '0;
      j <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      ansX <= '0;
      ansY <= '0;
      for (int i = 0; i < N_PTS; i++) begin
        px[i] <= '0;
        py[i] <= '0;
        vx[i] <= '0;
        vy[i] <= '0;
        bx[i] <= '0;
        by[i] <= '0;
        rank[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      out_last <= 1'b0;
      case (state)
        RECV:
          if (give_valid) begin
            px[idx] <= dataX;
            py[idx] <= dataY;
            idx <= nidx;
          end
        VEC: begin
          k <= '0;
          j <= '0;
          for (int i = 0; i < N_PTS; i++) begin
            vx[i] <= $signed({1'b0, px[i]}) - $signed({1'b0, px[0]});
            vy[i] <= $signed({1'b0, py[i]}) - $signed({1'b0, py[0]});
            rank[i] <= '0;
          end
        end
        RANK: begin
          if (j != k && (cneg || (czero && j < k))) rank[k] <= rank[k] + 1'b1;
          j <= j == LAST ? '0 : j + 1'b1;
          if (j == LAST) k <= k == LAST ? '0 : k + 1'b1;
        end
        PLACE: begin
          idx <= '0;
          for (int i = 0; i < N_PTS; i++) begin
            bx[rank[i]] <= REL_OUT != 0 ? vx[i] : $signed({1'b0, px[i]});
            by[rank[i]] <= REL_OUT != 0 ? vy[i] : $signed({1'b0, py[i]});
          end
        end
        OUT: begin
          out_valid <= 1'b1;
          out_last <= idx == LAST;
          ansX <= bx[idx];
          ansY <= by[idx];
          idx <= nidx;
        end
        default: idx <= '0;
      endcase
    end
`ifdef FENCE_AREA_EN
  // shoelace accumulator restarts on slot 0 so the full sum appears with out_last, then holds
  always_ff @(posedge clk or posedge reset)
    if (reset) area2 <= '0;
    else if (state == OUT) area2 <= idx == '0 ? AW'(c) : area2 + AW'(c);
`endif
endmodule
